pwm_peripheral: RTL and testbench

Sixteen-channel PWM controller driven by the SPI-written configuration registers (output enables, PWM-mode enables, duty cycle). Sits between the SPI register bank and the chip's 16 digital outputs, sequencing a shared prescaled 8-bit PWM counter across all channels. Duty and PWM-mode settings are double-buffered into shadow registers at period boundaries so every period is glitch-free. An idle/run FSM holds the counters in reset whenever every channel is disabled.

---
 rtl/pwm_peripheral.sv | 151 +++++++++++++++
 tb/tb_pwm_peripheral.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//   Sixteen-channel PWM controller. A shared prescaler divides clk down to a
//   PWM tick, and an 8-bit counter steps once per tick, so one PWM period is
//   256 ticks long. Every channel compares that counter against one shared
//   duty value.
//
//   The duty value and the per-channel PWM-mode bits are copied into shadow
//   registers only at period starts, so each period is glitch-free. The output
//   enables are not shadowed and take effect mid-period.
//
//   An IDLE/RUN FSM holds the counters at zero while every channel is
//   disabled. It restarts a fresh period, with a period_start pulse, as soon
//   as any channel is enabled again.
//
// Parameters
//   PRESCALE         clk cycles per PWM tick. Legal range is 2..65535.
// Ports
//   clk              system clock; all logic runs on its rising edge.
//   rst_n            asynchronous active-low reset.
//   en_reg_out_7_0   output enables, channels 7..0.
//   en_reg_out_15_8  output enables, channels 15..8.
//   en_reg_pwm_7_0   PWM-mode select, channels 7..0 (0 = static high).
//   en_reg_pwm_15_8  PWM-mode select, channels 15..8.
//   pwm_duty_cycle   shared duty value, 0x00..0xFF (0xFF = 100 %).
//   out              registered channel outputs; bit i is channel i.
//   period_start     one-clk pulse at the start of every PWM period.
// -----------------------------------------------------------------------------
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  // Prescaler width is just wide enough to hold PRESCALE-1.
  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e         state_q;
  logic [15:0]    en_q;
  logic [15:0]    pwm_sh_q;
  logic [7:0]     duty_sh_q;
  logic [PW-1:0]  presc_q;
  logic [7:0]     cnt_q;
  logic [15:0]    out_q;
  logic           period_start_q;

  logic           tick_s;
  logic           wrap_s;
  logic           pwm_level_s;
  logic [15:0]    out_d;

  // Tick, period wrap and PWM level, plus the next value of every channel.
  always_comb begin
    tick_s      = (presc_q == PRESC_LAST);
    wrap_s      = tick_s && (cnt_q == 8'hFF);
    // A duty of 0xFF means fully on; a plain compare would give 255/256.
    pwm_level_s = (duty_sh_q == 8'hFF) || (cnt_q < duty_sh_q);
    out_d       = 16'h0000;
    if (state_q == ST_RUN) begin
      // When pwm_sh is 0, the channel is static high. When it is 1, the
      // channel follows the PWM level. Either way it is gated by en_q.
      out_d = en_q & (~pwm_sh_q | {16{pwm_level_s}});
    end else begin
      out_d = 16'h0000;
    end
  end

  // IDLE/RUN sequencer: enables, counters, shadows and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      en_q           <= 16'h0000;
      pwm_sh_q       <= 16'h0000;
      duty_sh_q      <= 8'h00;
      presc_q        <= {PW{1'b0}};
      cnt_q          <= 8'h00;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      en_q  <= {en_reg_out_15_8, en_reg_out_7_0};
      out_q <= out_d;
      case (state_q)
        ST_IDLE: begin
          presc_q <= {PW{1'b0}};
          cnt_q   <= 8'h00;
          if (en_q != 16'h0000) begin
            // Entering RUN starts a fresh period from cnt 0.
            state_q        <= ST_RUN;
            pwm_sh_q       <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
            duty_sh_q      <= pwm_duty_cycle;
            period_start_q <= 1'b1;
          end else begin
            state_q        <= ST_IDLE;
            period_start_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (en_q == 16'h0000) begin
            // Going idle takes priority over a period start on the same
            // edge, so the shadows keep their values and no pulse is sent.
            state_q        <= ST_IDLE;
            presc_q        <= {PW{1'b0}};
            cnt_q          <= 8'h00;
            period_start_q <= 1'b0;
          end else begin
            state_q <= ST_RUN;
            if (tick_s) begin
              presc_q <= {PW{1'b0}};
              cnt_q   <= cnt_q + 8'h01;
            end else begin
              presc_q <= presc_q + PRESC_ONE;
              cnt_q   <= cnt_q;
            end
            if (wrap_s) begin
              pwm_sh_q       <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
              duty_sh_q      <= pwm_duty_cycle;
              period_start_q <= 1'b1;
            end else begin
              period_start_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          presc_q        <= {PW{1'b0}};
          cnt_q          <= 8'h00;
          period_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
//   Self-checking bench for pwm_peripheral with PRESCALE = 4.
//
//   The reference model tracks time in clk edges since the last entry into
//   RUN. From that count it works out the PWM count and the period boundaries
//   with plain division and modulo arithmetic.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

  localparam int P   = 4;
  localparam int PER = 256 * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] en_out = 16'h0000;
  logic [15:0] en_pwm = 16'h0000;
  logic [7:0]  duty = 8'h00;
  logic [15:0] out;
  logic        period_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(P)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  // ---------------- reference model ----------------
  logic [15:0] m_en;
  logic        m_run;
  int          m_t;
  logic [7:0]  m_duty;
  logic [15:0] m_pwm;
  logic [15:0] m_out;
  logic        m_ps;

  function automatic logic [15:0] model_out(input logic run, input logic [15:0] en,
                                            input logic [15:0] pwm, input logic [7:0] d,
                                            input int t);
    int c;
    logic lvl;
    logic [15:0] r;
    c   = (t / P) % 256;
    lvl = (d == 8'hFF) || (c < int'(d));
    r   = 16'h0000;
    if (run) begin
      for (int i = 0; i < 16; i++) begin
        r[i] = en[i] && (pwm[i] ? lvl : 1'b1);
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en <= 16'h0000; m_run <= 1'b0; m_t <= 0;
      m_duty <= 8'h00; m_pwm <= 16'h0000; m_out <= 16'h0000; m_ps <= 1'b0;
    end else begin
      m_out <= model_out(m_run, m_en, m_pwm, m_duty, m_t);
      m_en  <= en_out;
      if (!m_run) begin
        m_t <= 0;
        if (m_en != 16'h0000) begin
          m_run <= 1'b1; m_duty <= duty; m_pwm <= en_pwm; m_ps <= 1'b1;
        end else begin
          m_ps <= 1'b0;
        end
      end else if (m_en == 16'h0000) begin
        m_run <= 1'b0; m_t <= 0; m_ps <= 1'b0;
      end else begin
        m_t <= (m_t + 1) % PER;
        if (((m_t + 1) % PER) == 0) begin
          m_duty <= duty; m_pwm <= en_pwm; m_ps <= 1'b1;
        end else begin
          m_ps <= 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic settle_idle();
    en_out = 16'h0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_ps(input int budget, output bit seen);
    int k;
    seen = 1'b0;
    k = 0;
    while (!seen && k < budget) begin
      @(negedge clk);
      k++;
      if (period_start === 1'b1) seen = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      errors++; $display("FAIL reset_state: got out=%h ps=%b want 0000/0", out, period_start);
    end
    rst_n = 1'b1;
    en_out = 16'hFFFF; en_pwm = 16'h0000; duty = 8'h10;
    repeat (6) @(negedge clk);
    checks++;
    if (out !== 16'hFFFF) begin
      errors++; $display("FAIL reset_prerun: got out=%h want ffff", out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      errors++; $display("FAIL reset_async: got out=%h ps=%b want 0000/0", out, period_start);
    end
    en_out = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      checks++;
      if (out !== 16'h0000 || period_start !== 1'b0) begin
        errors++; $display("FAIL reset_release: got out=%h ps=%b want 0000/0", out, period_start);
      end
    end
  endtask

  task automatic test_static();
    settle_idle();
    en_out = 16'h0081; en_pwm = 16'h0000; duty = 8'($urandom_range(0, 255));
    for (int s = 1; s <= 1200; s++) begin
      @(negedge clk);
      checks++;
      if (s >= 3 && out !== 16'h0081) begin
        errors++; $display("FAIL static_out: sample %0d got %h want 0081", s, out);
      end else if (out !== m_out) begin
        errors++; $display("FAIL static_model: sample %0d got %h want %h", s, out, m_out);
      end
    end
  endtask

  task automatic test_duty80();
    bit seen;
    int hi;
    int stray;
    int other;
    settle_idle();
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
    wait_ps(8, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL duty80_start: got no period_start want pulse");
    end
    for (int p = 0; p < 2; p++) begin
      hi = 0; stray = 0; other = 0;
      for (int s = 1; s <= PER; s++) begin
        @(negedge clk);
        if (out[0] === 1'b1) hi++;
        if (out[15:1] !== 15'h0000) other++;
        if (s < PER && period_start !== 1'b0) stray++;
        if (s == PER) begin
          checks++;
          if (period_start !== 1'b1) begin
            errors++; $display("FAIL duty80_period: period %0d got ps=%b want 1 at %0d clk", p, period_start, PER);
          end
        end
      end
      checks++;
      if (hi != PER / 2) begin
        errors++; $display("FAIL duty80_high: period %0d got %0d want %0d", p, hi, PER / 2);
      end
      checks++;
      if (stray != 0 || other != 0) begin
        errors++; $display("FAIL duty80_stray: got stray_ps=%0d other_bits=%0d want 0/0", stray, other);
      end
    end
  endtask

  task automatic test_extremes();
    bit seen;
    int hi;
    logic [7:0] dv [2];
    dv[0] = 8'h00; dv[1] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      settle_idle();
      en_out = 16'h0001; en_pwm = 16'h0001; duty = dv[k];
      wait_ps(8, seen);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL extreme_start: duty %h got no pulse", dv[k]);
      end
      hi = 0;
      for (int s = 1; s <= 2 * PER; s++) begin
        @(negedge clk);
        if (out[0] === 1'b1) hi++;
      end
      checks++;
      if (hi != ((k == 0) ? 0 : 2 * PER)) begin
        errors++; $display("FAIL extreme_high: duty %h got %0d want %0d", dv[k], hi, (k == 0) ? 0 : 2 * PER);
      end
    end
  endtask

  task automatic test_shadow();
    bit seen;
    int hi;
    settle_idle();
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h40;
    wait_ps(8, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL shadow_start: got no pulse");
    end
    hi = 0;
    for (int s = 1; s <= PER; s++) begin
      @(negedge clk);
      if (out[0] === 1'b1) hi++;
      if (s == 400) duty = 8'hC0;
      if (s == PER) begin
        checks++;
        if (period_start !== 1'b1) begin
          errors++; $display("FAIL shadow_ps: got %b want 1", period_start);
        end
      end
    end
    checks++;
    if (hi != 256) begin
      errors++; $display("FAIL shadow_cur: got %0d want 256", hi);
    end
    hi = 0;
    for (int s = 1; s <= PER; s++) begin
      @(negedge clk);
      if (out[0] === 1'b1) hi++;
      if (s == 801) begin
        checks++;
        if (out[1] !== 1'b0) begin
          errors++; $display("FAIL shadow_en_early: got %b want 0", out[1]);
        end
      end
      if (s == 802) begin
        checks++;
        if (out[1] !== 1'b1) begin
          errors++; $display("FAIL shadow_en_late: got %b want 1", out[1]);
        end
      end
      if (s == 800) en_out = 16'h0003;
    end
    checks++;
    if (hi != 768) begin
      errors++; $display("FAIL shadow_next: got %0d want 768", hi);
    end
  endtask

  task automatic test_restart();
    bit seen;
    int hi;
    repeat (300) @(negedge clk);
    en_out = 16'h0000;
    repeat (2) @(negedge clk);
    checks++;
    if (out !== 16'h0000 || u_dut.cnt_q !== 8'h00 || u_dut.presc_q !== '0 || period_start !== 1'b0) begin
      errors++; $display("FAIL restart_stop: got out=%h cnt=%h presc=%0d ps=%b want 0", out, u_dut.cnt_q, u_dut.presc_q, period_start);
    end
    duty = 8'h80; en_pwm = 16'h0001; en_out = 16'h0001;
    wait_ps(8, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL restart_pulse: got no pulse");
    end
    hi = 0;
    for (int s = 1; s <= PER; s++) begin
      @(negedge clk);
      if (out[0] === 1'b1) hi++;
    end
    checks++;
    if (hi != PER / 2) begin
      errors++; $display("FAIL restart_high: got %0d want %0d", hi, PER / 2);
    end
  endtask

  task automatic test_random();
    int r;
    for (int s = 0; s < 8000; s++) begin
      @(negedge clk);
      checks++;
      if (out !== m_out || period_start !== m_ps) begin
        errors++; $display("FAIL random_model: cycle %0d got out=%h ps=%b want %h/%b", s, out, period_start, m_out, m_ps);
      end
      if ($urandom_range(0, 149) == 0) begin
        r = $urandom_range(0, 2);
        case (r)
          0: en_out = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
          1: en_pwm = 16'($urandom);
          default: begin
            r = $urandom_range(0, 3);
            duty = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
          end
        endcase
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_static();
    test_duty80();
    test_extremes();
    test_shadow();
    test_restart();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
